jesd_tx_link_ctrl: RTL and testbench
====================================

Name: jesd_tx_link_ctrl

Overview:
- Link-establishment sequencer for the JESD204B TX link layer.
- Keeps a local LMFC counter, which SYSREF realigns.
- Walks the link through the JESD204B phases: CGS (code-group sync), ILAS (initial lane alignment sequence) and DATA, following the receiver's SYNC~ line.
- Drives the link layer's 3-bit datapath select (0 = user data, 1 = continuous K, 2 = ILA, 3 = test sequence).
- Reports SYNC~ error pulses and resynchronisation requests.

Parameters:
- F, 2: octets per frame; the link carries one octet per clk.
- K, 16: frames per multiframe. MF_LEN = F*K must lie in 17..1024.
- RESYNC_CYC, 19: consecutive SYNC~-low cycles that form a resync request (5*F+9 at default).
- LMFC_W, derived: clog2(MF_LEN).

Ports:
- clk  in  1  character clock
- rst  in  1  synchronous, active-high reset
- i_link_en  in  1  link enable
- i_test_en  in  1  request link-layer test mode (honoured only from IDLE)
- i_sync_n  in  1  SYNC~ from receiver, already synchronised to clk
- i_sysref  in  1  SYSREF, single-cycle pulse, synchronous to clk
- o_link_mux  out  3  datapath select for link layer
- o_state  out  3  IDLE=0, CGS=1, ILAS=2, DATA=3, TEST=4
- o_lmfc_edge  out  1  high while lmfc_cnt==0
- o_ila_mf_idx  out  2  ILAS multiframe index 0..3 (0 outside ILAS)
- o_ila_octet  out  LMFC_W  octet index within ILAS multiframe (= lmfc_cnt in ILAS, else 0)
- o_data_rdy  out  1  high in DATA
- o_err_report  out  1  1-cycle pulse, short SYNC~ low seen in DATA
- o_err_cnt  out  8  count of error reports, saturates at 255
- o_realign_err  out  1  1-cycle pulse, SYSREF moved LMFC phase while in ILAS/DATA

Behaviour:
- Reset state: state=IDLE, lmfc_cnt=0, mf_idx=0, sync_low_cnt=0, o_err_cnt=0, pulses=0, o_link_mux=1.
  - o_lmfc_edge=1 in the first cycle after reset, since lmfc_cnt=0.
- Moore outputs: decoded from registered state/counters. A condition sampled at edge N changes outputs at cycle N+1.
- Mux mapping: IDLE→1, CGS→1, ILAS→2, DATA→0, TEST→3.
- LMFC counter:
  - Free-runs 0..MF_LEN-1 and wraps.
  - i_sysref=1 loads 0 at the next edge, taking priority over increment.
  - Realign is "misaligned" if i_sysref arrives while lmfc_cnt != MF_LEN-1.
- Transition priority, highest first: rst, then i_link_en=0 (any non-IDLE state → IDLE, except TEST), then the per-state rules below.
  - IDLE: i_test_en=1 → TEST; else i_link_en=1 → CGS.
  - TEST: i_test_en=0 → IDLE.
  - CGS: i_sync_n=1 and lmfc_cnt==MF_LEN-1 (no i_sysref that cycle) → ILAS, so the first ILAS octet has lmfc_cnt=0.
  - ILAS:
    - mf_idx increments at each LMFC wrap.
    - At the wrap with mf_idx==3 → DATA. ILAS therefore lasts exactly 4*MF_LEN cycles.
    - A misaligned i_sysref → CGS plus an o_realign_err pulse.
  - ILAS and DATA: sync_low_cnt counts consecutive i_sync_n=0 cycles and clears when i_sync_n=1. When it reaches RESYNC_CYC → CGS; no err_report is issued.
  - DATA:
    - i_sync_n returns to 1 after a low run of 1..RESYNC_CYC-1 → o_err_report pulse and o_err_cnt+1 (saturating). State stays DATA.
    - A misaligned i_sysref → o_realign_err pulse only; state stays DATA.
- sync_low_cnt saturates at RESYNC_CYC and is cleared on any state change.
- Simultaneous events:
  - i_link_en=0 overrides resync and err_report; no pulses are issued on disable.
  - A SYSREF in the same cycle as the CGS→ILAS condition blocks the transition; the wait continues to the next wrap.
- rst mid-operation: everything returns to reset values next cycle, including o_err_cnt.

Test Plan:
- Reset, i_link_en=1, i_sync_n=0 → o_state=CGS and o_link_mux=1 from cycle 2; both stay for 500 cycles; o_lmfc_edge period 32.
- In CGS, i_sync_n rises when lmfc_cnt=10 → ILAS entered when lmfc_cnt wraps to 0 (22 cycles later).
  - o_link_mux=2 for exactly 128 cycles; o_ila_mf_idx steps 0,1,2,3.
  - Then o_link_mux=0 and o_data_rdy=1.
- In DATA, i_sync_n low for 5 cycles → single o_err_report pulse the cycle after i_sync_n returns high; o_err_cnt=1; state stays DATA.
  - Repeat 300 times → o_err_cnt=255.
- In DATA, i_sync_n held low → CGS after the 19th low cycle; o_link_mux=1; no o_err_report.
- During ILAS, i_sysref at lmfc_cnt=5 → o_realign_err pulse, state=CGS, lmfc_cnt=0 next cycle.
  - i_sysref at lmfc_cnt=31 → no error; ILAS continues.
- i_link_en=0 mid-ILAS → IDLE next cycle.
  - In IDLE, i_test_en=1 → TEST with o_link_mux=3.
  - rst asserted mid-DATA → IDLE, o_err_cnt=0, o_link_mux=1.

Source files
------------

// File: rtl/jesd_tx_link_ctrl.sv
// JESD204B TX link-establishment sequencer: local LMFC counter with SYSREF realign,
// IDLE/CGS/ILAS/DATA/TEST phase control, SYNC~ error and resync detection.
module jesd_tx_link_ctrl #(
  parameter int F          = 2,
  parameter int K          = 16,
  parameter int RESYNC_CYC = 19,
  localparam int MF_LEN    = F * K,
  localparam int LMFC_W    = $clog2(MF_LEN),
  localparam int SL_W      = $clog2(RESYNC_CYC + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_link_en,
  input  logic              i_test_en,
  input  logic              i_sync_n,
  input  logic              i_sysref,
  output logic [2:0]        o_link_mux,
  output logic [2:0]        o_state,
  output logic              o_lmfc_edge,
  output logic [1:0]        o_ila_mf_idx,
  output logic [LMFC_W-1:0] o_ila_octet,
  output logic              o_data_rdy,
  output logic              o_err_report,
  output logic [7:0]        o_err_cnt,
  output logic              o_realign_err
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CGS  = 3'd1,
    ST_ILAS = 3'd2,
    ST_DATA = 3'd3,
    ST_TEST = 3'd4
  } state_e;

  function automatic logic [2:0] mux_of(input state_e s);
    case (s)
      ST_IDLE: mux_of = 3'd1;
      ST_CGS:  mux_of = 3'd1;
      ST_ILAS: mux_of = 3'd2;
      ST_DATA: mux_of = 3'd0;
      ST_TEST: mux_of = 3'd3;
      default: mux_of = 3'd1;
    endcase
  endfunction

  state_e            state_q, state_d;
  logic [LMFC_W-1:0] lmfc_q, lmfc_d;
  logic [1:0]        mf_idx_q, mf_idx_d;
  logic [SL_W-1:0]   sync_low_q, sync_low_d, sync_run;
  logic [7:0]        err_cnt_q, err_cnt_d;
  logic              err_pulse_q, err_pulse_d;
  logic              realign_q, realign_d;
  logic [2:0]        link_mux_q;
  logic              lmfc_edge_q;
  logic [LMFC_W-1:0] ila_octet_q, ila_octet_d;
  logic              data_rdy_q;
  logic              lmfc_wrap, misaligned, resync_hit, short_err;

  // LMFC next value and the SYNC~ low-run bookkeeping shared by the FSM
  always_comb begin
    lmfc_wrap  = (lmfc_q == LMFC_W'(MF_LEN - 1));
    misaligned = i_sysref && !lmfc_wrap;
    if (i_sysref || lmfc_wrap) begin
      lmfc_d = '0;
    end else begin
      lmfc_d = lmfc_q + LMFC_W'(1);
    end
    if (i_sync_n) begin
      sync_run = '0;
    end else if (sync_low_q == SL_W'(RESYNC_CYC)) begin
      sync_run = sync_low_q;
    end else begin
      sync_run = sync_low_q + SL_W'(1);
    end
    resync_hit = (sync_run == SL_W'(RESYNC_CYC));
    short_err  = i_sync_n && (sync_low_q != '0);
  end

  // Phase sequencing; link disable outranks every pulse and resync decision
  always_comb begin
    state_d     = state_q;
    mf_idx_d    = mf_idx_q;
    err_cnt_d   = err_cnt_q;
    err_pulse_d = 1'b0;
    realign_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_test_en)      state_d = ST_TEST;
        else if (i_link_en) state_d = ST_CGS;
        else                state_d = ST_IDLE;
      end
      ST_TEST: begin
        if (!i_test_en) state_d = ST_IDLE;
        else            state_d = ST_TEST;
      end
      ST_CGS: begin
        if (!i_link_en)                               state_d = ST_IDLE;
        else if (i_sync_n && lmfc_wrap && !i_sysref)  state_d = ST_ILAS;
        else                                          state_d = ST_CGS;
      end
      ST_ILAS: begin
        if (!i_link_en) begin
          state_d = ST_IDLE;
        end else if (misaligned) begin
          state_d   = ST_CGS;
          realign_d = 1'b1;
        end else if (resync_hit) begin
          state_d = ST_CGS;
        end else if (lmfc_wrap) begin
          if (mf_idx_q == 2'd3) state_d = ST_DATA;
          else                  mf_idx_d = mf_idx_q + 2'd1;
        end else begin
          state_d = ST_ILAS;
        end
      end
      ST_DATA: begin
        if (!i_link_en) begin
          state_d = ST_IDLE;
        end else begin
          realign_d = misaligned;
          if (resync_hit) begin
            state_d = ST_CGS;
          end else if (short_err) begin
            err_pulse_d = 1'b1;
            if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
            else                    err_cnt_d = err_cnt_q;
          end else begin
            state_d = ST_DATA;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Low-run and multiframe index restart whenever the phase changes
    if (state_d != state_q) begin
      sync_low_d = '0;
      mf_idx_d   = 2'd0;
    end else if (state_q == ST_ILAS || state_q == ST_DATA) begin
      sync_low_d = sync_run;
    end else begin
      sync_low_d = '0;
    end
    if (state_d == ST_ILAS) ila_octet_d = lmfc_d;
    else                    ila_octet_d = '0;
  end

  // State, counters and registered output decode
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      lmfc_q      <= '0;
      mf_idx_q    <= 2'd0;
      sync_low_q  <= '0;
      err_cnt_q   <= 8'd0;
      err_pulse_q <= 1'b0;
      realign_q   <= 1'b0;
      link_mux_q  <= 3'd1;
      lmfc_edge_q <= 1'b1;
      ila_octet_q <= '0;
      data_rdy_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      lmfc_q      <= lmfc_d;
      mf_idx_q    <= mf_idx_d;
      sync_low_q  <= sync_low_d;
      err_cnt_q   <= err_cnt_d;
      err_pulse_q <= err_pulse_d;
      realign_q   <= realign_d;
      link_mux_q  <= mux_of(state_d);
      lmfc_edge_q <= (lmfc_d == '0);
      ila_octet_q <= ila_octet_d;
      data_rdy_q  <= (state_d == ST_DATA);
    end
  end

  assign o_state       = state_q;
  assign o_link_mux    = link_mux_q;
  assign o_lmfc_edge   = lmfc_edge_q;
  assign o_ila_mf_idx  = mf_idx_q;
  assign o_ila_octet   = ila_octet_q;
  assign o_data_rdy    = data_rdy_q;
  assign o_err_report  = err_pulse_q;
  assign o_err_cnt     = err_cnt_q;
  assign o_realign_err = realign_q;

endmodule

// File: tb/tb_jesd_tx_link_ctrl.sv
// Directed bench for jesd_tx_link_ctrl: a table of single-cycle vectors for IDLE/TEST/CGS
// entry, then hand-written sequences for CGS, ILAS, DATA errors, resync, realign and reset.
module tb_jesd_tx_link_ctrl;
  localparam int MF = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, link_en, test_en, sync_n, sysref;
  logic [2:0] link_mux, state;
  logic       lmfc_edge, data_rdy, err_report, realign_err;
  logic [1:0] ila_mf_idx;
  logic [4:0] ila_octet;
  logic [7:0] err_cnt;

  int n_vec = 0;
  int n_bad = 0;
  int lm    = 0;

  jesd_tx_link_ctrl dut (
    .clk(clk), .rst(rst), .i_link_en(link_en), .i_test_en(test_en),
    .i_sync_n(sync_n), .i_sysref(sysref), .o_link_mux(link_mux), .o_state(state),
    .o_lmfc_edge(lmfc_edge), .o_ila_mf_idx(ila_mf_idx), .o_ila_octet(ila_octet),
    .o_data_rdy(data_rdy), .o_err_report(err_report), .o_err_cnt(err_cnt),
    .o_realign_err(realign_err)
  );

  typedef struct {
    logic r, le, te, sn, sr;
    int   st, mux, edge_e, ec;
  } vec_t;
  vec_t tbl[11];

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (lmfc %0d)", name, act, exp, lm);
    end
  endtask

  // One clock: the expected LMFC phase follows the inputs sampled at this edge
  task automatic tick();
    int nxt;
    nxt = (rst || sysref) ? 0 : ((lm == MF - 1) ? 0 : lm + 1);
    @(posedge clk);
    #1;
    lm = nxt;
  endtask

  task automatic chk_core(input string tag, input int st, input int mux);
    chk({tag, " state"}, int'(state), st);
    chk({tag, " mux"}, int'(link_mux), mux);
    chk({tag, " edge"}, int'(lmfc_edge), (lm == 0) ? 1 : 0);
  endtask

  task automatic cgs_to_ilas(input string tag);
    do begin
      tick();
      if (lm != 0) chk_core({tag, " cgs"}, 1, 1);
    end while (lm != 0);
  endtask

  task automatic do_ilas(input string tag);
    for (int i = 0; i < 4 * MF; i++) begin
      if (i != 0) tick();
      chk({tag, " ila state"}, int'(state), 2);
      chk({tag, " ila mux"}, int'(link_mux), 2);
      chk({tag, " ila mf"}, int'(ila_mf_idx), i / MF);
      chk({tag, " ila octet"}, int'(ila_octet), i % MF);
      chk({tag, " ila rdy"}, int'(data_rdy), 0);
    end
    tick();
    chk({tag, " data state"}, int'(state), 3);
    chk({tag, " data mux"}, int'(link_mux), 0);
    chk({tag, " data rdy"}, int'(data_rdy), 1);
    chk({tag, " data mf"}, int'(ila_mf_idx), 0);
    chk({tag, " data octet"}, int'(ila_octet), 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //          r     le    te    sn    sr   st mux edge ec
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1, 1, 0};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1, 0, 0};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4, 3, 0, 0};
    tbl[3]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4, 3, 0, 0};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4, 3, 0, 0};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1, 0, 0};
    tbl[6]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4, 3, 0, 0};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0, 1, 0, 0};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1, 1, 0, 0};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1, 0, 0};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1, 1, 0};

    rst = 1'b1; link_en = 1'b0; test_en = 1'b0; sync_n = 1'b1; sysref = 1'b0;
    #2;
    for (int i = 0; i < 11; i++) begin
      rst = tbl[i].r; link_en = tbl[i].le; test_en = tbl[i].te;
      sync_n = tbl[i].sn; sysref = tbl[i].sr;
      tick();
      chk($sformatf("vec%0d state", i), int'(state), tbl[i].st);
      chk($sformatf("vec%0d mux", i), int'(link_mux), tbl[i].mux);
      chk($sformatf("vec%0d edge", i), int'(lmfc_edge), tbl[i].edge_e);
      chk($sformatf("vec%0d errcnt", i), int'(err_cnt), tbl[i].ec);
    end

    // CGS holds while SYNC~ is low
    rst = 1'b0; link_en = 1'b1; sync_n = 1'b0;
    for (int i = 0; i < 500; i++) begin
      tick();
      chk_core("cgs_hold", 1, 1);
    end

    // SYNC~ rises mid-multiframe; ILAS starts at the next LMFC wrap
    while (lm != 10) begin
      tick();
      chk_core("cgs_pre", 1, 1);
    end
    sync_n = 1'b1;
    for (int i = 0; i < 22; i++) begin
      tick();
      if (i < 21) chk_core("cgs_wait", 1, 1);
    end
    do_ilas("b");

    // Short SYNC~ lows in DATA, counter saturates at 255
    for (int n = 1; n <= 300; n++) begin
      sync_n = 1'b0;
      for (int k = 0; k < 5; k++) begin
        tick();
        chk("short_low state", int'(state), 3);
        chk("short_low errrep", int'(err_report), 0);
      end
      sync_n = 1'b1;
      tick();
      chk("err pulse", int'(err_report), 1);
      chk("err cnt", int'(err_cnt), (n > 255) ? 255 : n);
      chk("err state", int'(state), 3);
      tick();
      chk("err pulse end", int'(err_report), 0);
    end

    // Held SYNC~ low forces resync after 19 cycles, no error report
    sync_n = 1'b0;
    for (int k = 1; k <= 22; k++) begin
      tick();
      chk("resync state", int'(state), (k < 19) ? 3 : 1);
      chk("resync errrep", int'(err_report), 0);
      if (k >= 19) chk("resync mux", int'(link_mux), 1);
    end
    chk("resync errcnt", int'(err_cnt), 255);

    // Misaligned SYSREF in ILAS drops to CGS; aligned SYSREF is harmless
    sync_n = 1'b1;
    cgs_to_ilas("e1");
    chk("e1 ilas", int'(state), 2);
    while (lm != 5) begin
      tick();
      chk("e1 ilas run", int'(state), 2);
    end
    sysref = 1'b1;
    tick();
    sysref = 1'b0;
    chk("realign pulse", int'(realign_err), 1);
    chk("realign state", int'(state), 1);
    chk("realign lmfc0", int'(lmfc_edge), 1);
    tick();
    chk("realign pulse end", int'(realign_err), 0);
    cgs_to_ilas("e2");
    chk("e2 ilas", int'(state), 2);
    while (lm != MF - 1) begin
      tick();
      chk("e2 ilas run", int'(state), 2);
    end
    sysref = 1'b1;
    tick();
    sysref = 1'b0;
    chk("aligned state", int'(state), 2);
    chk("aligned realign", int'(realign_err), 0);
    chk("aligned mf", int'(ila_mf_idx), 1);
    chk("aligned edge", int'(lmfc_edge), 1);

    // Disable mid-ILAS, then test mode from IDLE
    tick(); tick();
    link_en = 1'b0;
    tick();
    chk("dis state", int'(state), 0);
    chk("dis mux", int'(link_mux), 1);
    chk("dis mf", int'(ila_mf_idx), 0);
    test_en = 1'b1;
    tick();
    chk("test state", int'(state), 4);
    chk("test mux", int'(link_mux), 3);
    test_en = 1'b0;
    tick();
    chk("test exit", int'(state), 0);

    // SYSREF coincident with the CGS exit condition postpones ILAS by a multiframe
    link_en = 1'b1;
    tick();
    chk("g cgs", int'(state), 1);
    while (lm != MF - 1) begin
      tick();
      chk("g cgs run", int'(state), 1);
    end
    sysref = 1'b1;
    tick();
    sysref = 1'b0;
    chk("blocked state", int'(state), 1);
    cgs_to_ilas("g");
    do_ilas("g");
    chk("g errcnt kept", int'(err_cnt), 255);

    // Disable coinciding with SYNC~ return: no error pulse
    sync_n = 1'b0;
    tick(); tick(); tick();
    sync_n = 1'b1;
    link_en = 1'b0;
    tick();
    chk("dis2 state", int'(state), 0);
    chk("dis2 errrep", int'(err_report), 0);
    tick();
    chk("dis2 errrep2", int'(err_report), 0);

    // Reset in DATA clears everything including the error counter
    link_en = 1'b1;
    tick();
    cgs_to_ilas("h");
    do_ilas("h");
    tick(); tick();
    rst = 1'b1;
    tick();
    chk("rst state", int'(state), 0);
    chk("rst errcnt", int'(err_cnt), 0);
    chk("rst mux", int'(link_mux), 1);
    chk("rst edge", int'(lmfc_edge), 1);
    chk("rst rdy", int'(data_rdy), 0);
    rst = 1'b0;
    link_en = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
